// File: rtl/sobel_pkg.sv
// Shared constants, FSM state type and output saturation helper for the Sobel window feeder.
package sobel_pkg;

    localparam int PX_W  = 8;
    localparam int MAG_W = 17;

    // Phase values on the count bus. The datapath folds its nine taps over
    // CNT_FIRST..CNT_LAST, and its magnitude is valid once count reaches CNT_RESULT.
    localparam logic [3:0] CNT_IDLE   = 4'd0;
    localparam logic [3:0] CNT_FIRST  = 4'd2;
    localparam logic [3:0] CNT_LAST   = CNT_FIRST + 4'd8;
    localparam logic [3:0] CNT_RESULT = CNT_LAST + 4'd1;

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_COMPUTE = 1'b1
    } fsm_state_e;

    // Clamp a magnitude to the pixel range.
    function automatic logic [PX_W-1:0] sat_px(input logic [MAG_W-1:0] mag);
        return (|mag[MAG_W-1:PX_W]) ? {PX_W{1'b1}} : mag[PX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row pixel history: lb1 holds row r-2 and lb0 holds row r-1 at each column.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [COL_W-1:0] col,
    input  logic [PX_W-1:0]  wr_px,
    output logic [PX_W-1:0]  top,
    output logic [PX_W-1:0]  mid
);

    logic [PX_W-1:0] lb0_mem [IMG_W];
    logic [PX_W-1:0] lb1_mem [IMG_W];

    // Asynchronous read of the current column so the window can load in the transfer cycle.
    always_comb begin
        top = lb1_mem[col];
        mid = lb0_mem[col];
    end

    // One read-modify-write per accepted pixel: age row r-1 into r-2, store the new pixel.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb1_mem[col] <= lb0_mem[col];
            lb0_mem[col] <= wr_px;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster pixel intake, 3x3 window formation, phase sequencing for the folding Sobel datapath,
// and registration of the resulting magnitude with its centre-pixel address.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PX_W-1:0]   in_px,
    output logic [3:0]        count,
    output logic [PX_W-1:0]   px_1,
    output logic [PX_W-1:0]   px_2,
    output logic [PX_W-1:0]   px_3,
    output logic [PX_W-1:0]   px_4,
    output logic [PX_W-1:0]   px_5,
    output logic [PX_W-1:0]   px_6,
    output logic [PX_W-1:0]   px_7,
    output logic [PX_W-1:0]   px_8,
    output logic [PX_W-1:0]   px_9,
    input  logic [MAG_W-1:0]  sobel_out,
    output logic              out_valid,
    output logic [MAG_W-1:0]  out_data,
    output logic [PX_W-1:0]   out_sat,
    output logic [ADDR_W-1:0] out_addr,
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    fsm_state_e state_q, state_d;
    logic [3:0] count_q, count_d;
    logic in_ready_q, in_ready_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [8:0][PX_W-1:0] win_q, win_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic pend_last_q, pend_last_d;
    logic out_valid_q, out_valid_d;
    logic [MAG_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic frame_done_q, frame_done_d;

    logic xfer;
    logic lb_wr;
    logic [PX_W-1:0] lb_top;
    logic [PX_W-1:0] lb_mid;
    logic [ADDR_W-1:0] centre_addr;

    sobel_line_buffer #(
        .IMG_W (IMG_W),
        .COL_W (COL_W)
    ) u_line_buffer (
        .clk   (clk),
        .wr_en (lb_wr),
        .col   (col_q),
        .wr_px (in_px),
        .top   (lb_top),
        .mid   (lb_mid)
    );

    // A pixel moves only when the registered ready is high, which implies the ACCEPT state.
    always_comb begin
        xfer        = in_valid & in_ready_q;
        centre_addr = ADDR_W'((int'(row_q) - 1) * IMG_W + (int'(col_q) - 1));
    end

    // Next-state logic: window shift and raster counters on transfer, phase counting in COMPUTE.
    always_comb begin
        state_d      = state_q;
        count_d      = CNT_IDLE;
        row_d        = row_q;
        col_d        = col_q;
        win_d        = win_q;
        pend_addr_d  = pend_addr_q;
        pend_last_d  = pend_last_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        lb_wr        = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                if (xfer) begin
                    lb_wr    = 1'b1;
                    win_d[0] = win_q[1];
                    win_d[1] = win_q[2];
                    win_d[2] = lb_top;
                    win_d[3] = win_q[4];
                    win_d[4] = win_q[5];
                    win_d[5] = lb_mid;
                    win_d[6] = win_q[7];
                    win_d[7] = win_q[8];
                    win_d[8] = in_px;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if ((row_q >= ROW_W'(2)) && (col_q >= COL_W'(2))) begin
                        state_d     = ST_COMPUTE;
                        pend_addr_d = centre_addr;
                        pend_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    end
                end
            end
            ST_COMPUTE: begin
                if (count_q == CNT_RESULT) begin
                    state_d      = ST_ACCEPT;
                    out_valid_d  = 1'b1;
                    frame_done_d = pend_last_q;
                    out_data_d   = sobel_out;
                    out_addr_d   = pend_addr_q;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
        in_ready_d = (state_d == ST_ACCEPT);
    end

    // State and datapath registers; reset drops any in-flight window and restarts at pixel (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_ACCEPT;
            count_q      <= CNT_IDLE;
            in_ready_q   <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            win_q        <= '0;
            pend_addr_q  <= '0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_q        <= win_d;
            pend_addr_q  <= pend_addr_d;
            pend_last_q  <= pend_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign count      = count_q;
    assign px_1       = win_q[0];
    assign px_2       = win_q[1];
    assign px_3       = win_q[2];
    assign px_4       = win_q[3];
    assign px_5       = win_q[4];
    assign px_6       = win_q[5];
    assign px_7       = win_q[6];
    assign px_8       = win_q[7];
    assign px_9       = win_q[8];
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = sat_px(out_data_q);
    assign out_addr   = out_addr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 4x4 image with a behavioural Sobel datapath.
module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 14;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid;
    logic in_ready;
    logic [7:0] in_px;
    logic [3:0] count;
    logic [7:0] px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9;
    logic [MAG_W-1:0] sobel_out;
    logic out_valid;
    logic [MAG_W-1:0] out_data;
    logic [7:0] out_sat;
    logic [ADDR_W-1:0] out_addr;
    logic frame_done;

    typedef struct {
        logic [MAG_W-1:0]  data;
        logic [7:0]        sat;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } exp_t;

    typedef struct {
        string name;
        int    kind;
        int    mag;
        int    sat;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[3];
    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit cnt_active = 1'b0;
    int exp_cnt = 0;
    bit valid_due = 1'b0;
    logic [71:0] exp_win = '0;
    int results_seen = 0;
    int fd_seen = 0;
    int img[IMG_H][IMG_W];
    int tb_r = 0;
    int tb_c = 0;
    bit use_const = 1'b0;
    int const_mag = 0;
    int const_sat = 0;
    int rs0, fd0, wait_n;

    always #5 clk = ~clk;

    sobel_window_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_px      (in_px),
        .count      (count),
        .px_1       (px_1),
        .px_2       (px_2),
        .px_3       (px_3),
        .px_4       (px_4),
        .px_5       (px_5),
        .px_6       (px_6),
        .px_7       (px_7),
        .px_8       (px_8),
        .px_9       (px_9),
        .sobel_out  (sobel_out),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_addr   (out_addr),
        .frame_done (frame_done)
    );

    function automatic int sobel_mag(input int p1, input int p2, input int p3, input int p4,
                                     input int p6, input int p7, input int p8, input int p9);
        int gx, gy;
        gx = (p3 + 2 * p6 + p9) - (p1 + 2 * p4 + p7);
        gy = (p7 + 2 * p8 + p9) - (p1 + 2 * p2 + p3);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    // Stand-in datapath: real magnitude only in the result phase, junk otherwise.
    always_comb begin
        if (count == CNT_RESULT)
            sobel_out = MAG_W'(sobel_mag(px_1, px_2, px_3, px_4, px_6, px_7, px_8, px_9));
        else
            sobel_out = 17'h1F0F0;
    end

    function automatic int pixel(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c >= 2) ? 255 : 0;
            2:       return 10 * r;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_in_ready"}, in_ready, 0);
        check_output({tag, "_count"}, count, 0);
        check_output({tag, "_px"}, {px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9}, 0);
        check_output({tag, "_out_valid"}, out_valid, 0);
        check_output({tag, "_out_data"}, out_data, 0);
        check_output({tag, "_out_sat"}, out_sat, 0);
        check_output({tag, "_out_addr"}, out_addr, 0);
        check_output({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Offer one pixel (after optional idle gap) and record its expectation once it transfers.
    task automatic apply_stimulus(input logic [7:0] px, input int gap);
        int waited;
        bit win_start;
        exp_t e;
        int m;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_px = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_px = px;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_output("in_ready_timeout", in_ready, 1);
            return;
        end
        img[tb_r][tb_c] = int'(px);
        win_start = 1'b0;
        if (tb_r >= 2 && tb_c >= 2) begin
            m = use_const ? const_mag
                : sobel_mag(img[tb_r-2][tb_c-2], img[tb_r-2][tb_c-1], img[tb_r-2][tb_c],
                            img[tb_r-1][tb_c-2], img[tb_r-1][tb_c], img[tb_r][tb_c-2],
                            img[tb_r][tb_c-1], img[tb_r][tb_c]);
            e.data = MAG_W'(m);
            e.sat  = use_const ? 8'(const_sat) : ((m > 255) ? 8'd255 : 8'(m));
            e.addr = ADDR_W'((tb_r - 1) * IMG_W + (tb_c - 1));
            e.last = (tb_r == IMG_H - 1) && (tb_c == IMG_W - 1);
            exp_q.push_back(e);
            exp_win = {8'(img[tb_r-2][tb_c-2]), 8'(img[tb_r-2][tb_c-1]), 8'(img[tb_r-2][tb_c]),
                       8'(img[tb_r-1][tb_c-2]), 8'(img[tb_r-1][tb_c-1]), 8'(img[tb_r-1][tb_c]),
                       8'(img[tb_r][tb_c-2]), 8'(img[tb_r][tb_c-1]), 8'(img[tb_r][tb_c])};
            win_start = 1'b1;
        end
        if (tb_c == IMG_W - 1) begin
            tb_c = 0;
            tb_r = (tb_r == IMG_H - 1) ? 0 : tb_r + 1;
        end else begin
            tb_c++;
        end
        @(posedge clk);
        #1;
        if (win_start) begin
            cnt_active = 1'b1;
            exp_cnt = 0;
        end
    endtask

    task automatic run_frame(input int kind, input bit uc, input int cm, input int cs, input bit gaps);
        int gap;
        use_const = uc;
        const_mag = cm;
        const_sat = cs;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                gap = (gaps && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                apply_stimulus(8'(pixel(kind, r, c)), gap);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || cnt_active || valid_due) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Cycle-accurate watcher: phase sequence, window contents, result timing and scoreboard.
    task automatic monitor_outputs();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_output("out_valid", out_valid, valid_due);
                valid_due = 1'b0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_result", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("out_data", out_data, e.data);
                        check_output("out_sat", out_sat, e.sat);
                        check_output("out_addr", out_addr, e.addr);
                        check_output("frame_done", frame_done, e.last);
                        results_seen++;
                        if (frame_done) fd_seen++;
                    end
                end else if (frame_done) begin
                    check_output("frame_done_stray", frame_done, 0);
                end
                if (cnt_active) begin
                    check_output("count", count, exp_cnt);
                    if (exp_cnt == int'(CNT_FIRST) || exp_cnt == int'(CNT_LAST) || exp_cnt == int'(CNT_RESULT))
                        check_output("window", {px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9}, exp_win);
                    exp_cnt++;
                    if (exp_cnt > int'(CNT_RESULT)) begin
                        cnt_active = 1'b0;
                        valid_due = 1'b1;
                    end
                end else begin
                    check_output("count_idle", count, 0);
                end
            end
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_px = 8'd0;
        vecs[0] = '{"const100", 0, 0, 0};
        vecs[1] = '{"edge", 1, 1020, 255};
        vecs[2] = '{"ramp", 2, 80, 80};

        fork
            monitor_outputs();
            begin
                #200000;
                $display("[TB] FAIL watchdog: simulation time limit reached");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        #1 reset = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 mon_en = 1'b1;

        // Table-driven frames with known constant results.
        for (int i = 0; i < 3; i++) begin
            $display("[TB] vector %s", vecs[i].name);
            rs0 = results_seen;
            fd0 = fd_seen;
            run_frame(vecs[i].kind, 1'b1, vecs[i].mag, vecs[i].sat, 1'b0);
            wait_drain();
            check_output({vecs[i].name, "_results"}, results_seen - rs0, 4);
            check_output({vecs[i].name, "_frame_done"}, fd_seen - fd0, 1);
        end

        // Random image with idle gaps and offers during COMPUTE.
        $display("[TB] random frames with gaps");
        for (int k = 0; k < 2; k++) begin
            rs0 = results_seen;
            run_frame(3, 1'b0, 0, 0, 1'b1);
            wait_drain();
            check_output("random_results", results_seen - rs0, 4);
        end

        // Reset in the middle of the first window's computation.
        $display("[TB] reset during compute");
        use_const = 1'b1;
        const_mag = 1020;
        const_sat = 255;
        for (int idx = 0; idx < 2 * IMG_W + 3; idx++)
            apply_stimulus(8'(pixel(1, idx / IMG_W, idx % IMG_W)), 0);
        wait_n = 0;
        while (count != 4'd6 && wait_n < 30) begin
            @(posedge clk);
            #2;
            wait_n++;
        end
        if (wait_n >= 30) check_output("count6_timeout", count, 6);
        mon_en = 1'b0;
        in_valid = 1'b0;
        reset = 1'b0;
        #1 check_reset_state("midreset");
        exp_q.delete();
        cnt_active = 1'b0;
        valid_due = 1'b0;
        tb_r = 0;
        tb_c = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 mon_en = 1'b1;
        rs0 = results_seen;
        run_frame(2, 1'b1, 80, 80, 1'b0);
        wait_drain();
        check_output("after_reset_results", results_seen - rs0, 4);

        // Two back-to-back edge frames.
        $display("[TB] back-to-back frames");
        rs0 = results_seen;
        fd0 = fd_seen;
        run_frame(1, 1'b1, 1020, 255, 1'b0);
        run_frame(1, 1'b1, 1020, 255, 1'b0);
        wait_drain();
        check_output("b2b_results", results_seen - rs0, 8);
        check_output("b2b_frame_done", fd_seen - fd0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
